// File: rtl/zeroheti_obi_apb_bridge.sv
// OBI -> APB4 bridge serving several APB subordinates.
// One contiguous address window starting at BaseAddr is split into NumPeriphs slots of
// PeriphSize bytes. Each slot has its own psel/pready/prdata/pslverr. Accesses outside the
// window complete immediately with an error. A PREADY timeout aborts hung accesses.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   obi_req_i / obi_gnt_o         OBI handshake; one transaction outstanding
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i         OBI request payload
//   obi_rvalid_o, obi_rdata_o,
//   obi_err_o                     OBI response (one cycle, no backpressure)
//   paddr_o, pwrite_o, pwdata_o,
//   pstrb_o, pprot_o, psel_o,
//   penable_o                     APB4 requester outputs (zero while no slot is selected)
//   pready_i, prdata_i, pslverr_i per-slot APB4 responses
module zeroheti_obi_apb_bridge #(
  parameter int unsigned NumPeriphs = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(32'h0003_0000),
  parameter logic [AddrWidth-1:0] PeriphSize = AddrWidth'(32'h0000_1000),
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                obi_req_i,
  output logic                                obi_gnt_o,
  input  logic [AddrWidth-1:0]                obi_addr_i,
  input  logic                                obi_we_i,
  input  logic [DataWidth/8-1:0]              obi_be_i,
  input  logic [DataWidth-1:0]                obi_wdata_i,
  output logic                                obi_rvalid_o,
  output logic [DataWidth-1:0]                obi_rdata_o,
  output logic                                obi_err_o,
  output logic [AddrWidth-1:0]                paddr_o,
  output logic                                pwrite_o,
  output logic [DataWidth-1:0]                pwdata_o,
  output logic [DataWidth/8-1:0]              pstrb_o,
  output logic [2:0]                          pprot_o,
  output logic [NumPeriphs-1:0]               psel_o,
  output logic                                penable_o,
  input  logic [NumPeriphs-1:0]               pready_i,
  input  logic [NumPeriphs-1:0][DataWidth-1:0] prdata_i,
  input  logic [NumPeriphs-1:0]               pslverr_i
);

  localparam int unsigned IdxW = (NumPeriphs > 1) ? $clog2(NumPeriphs) : 1;
  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam int unsigned PeriphShift = $clog2(PeriphSize);
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic                   we_q;
  logic [DataWidth/8-1:0] be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [IdxW-1:0]        idx_q;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Address decode of the incoming request; only used on the grant cycle.
  logic [AddrWidth-1:0] dec_off;
  logic [AddrWidth-1:0] dec_slot;
  logic                 dec_hit;

  assign dec_off  = obi_addr_i - BaseAddr;
  assign dec_slot = dec_off >> PeriphShift;
  assign dec_hit  = (obi_addr_i >= BaseAddr) && (dec_slot < AddrWidth'(NumPeriphs));

  assign obi_gnt_o = obi_req_i && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (obi_gnt_o) begin
          if (dec_hit) begin
            state_d = StSetup;
          end else begin
            // Decode miss: answer straight away, no APB activity.
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        // PREADY takes priority over the timeout on the same cycle.
        if (pready_i[idx_q]) begin
          rdata_d = we_q ? '0 : prdata_i[idx_q];
          err_d   = pslverr_i[idx_q];
          state_d = StResp;
        end else if ((TimeoutCycles != 0) && (cnt_q == TimeoutLast)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (obi_gnt_o) begin
        addr_q  <= obi_addr_i;
        we_q    <= obi_we_i;
        be_q    <= obi_be_i;
        wdata_q <= obi_wdata_i;
        idx_q   <= dec_slot[IdxW-1:0];
      end
    end
  end

  logic                  apb_active;
  logic                  resp;
  logic [NumPeriphs-1:0] sel_onehot;

  assign apb_active = (state_q == StSetup) || (state_q == StAccess);
  assign resp       = (state_q == StResp);
  assign sel_onehot = NumPeriphs'(1) << idx_q;

  assign psel_o    = apb_active ? sel_onehot : '0;
  assign penable_o = (state_q == StAccess);
  assign paddr_o   = apb_active ? addr_q : '0;
  assign pwrite_o  = apb_active && we_q;
  assign pwdata_o  = apb_active ? wdata_q : '0;
  assign pstrb_o   = (apb_active && we_q) ? be_q : '0;
  assign pprot_o   = 3'b000;

  assign obi_rvalid_o = resp;
  assign obi_rdata_o  = resp ? rdata_q : '0;
  assign obi_err_o    = resp && err_q;

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
module tb_zeroheti_obi_apb_bridge;

  localparam logic [31:0] Base = 32'h0003_0000;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              obi_req_i = 1'b0;
  logic              obi_gnt_o;
  logic [31:0]       obi_addr_i = '0;
  logic              obi_we_i = 1'b0;
  logic [3:0]        obi_be_i = '0;
  logic [31:0]       obi_wdata_i = '0;
  logic              obi_rvalid_o;
  logic [31:0]       obi_rdata_o;
  logic              obi_err_o;
  logic [31:0]       paddr_o;
  logic              pwrite_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic [2:0]        pprot_o;
  logic [3:0]        psel_o;
  logic              penable_o;
  logic [3:0]        pready_i;
  logic [3:0][31:0]  prdata_i;
  logic [3:0]        pslverr_i;

  zeroheti_obi_apb_bridge #(
    .NumPeriphs   (4),
    .AddrWidth    (32),
    .DataWidth    (32),
    .BaseAddr     (Base),
    .PeriphSize   (32'h0000_1000),
    .TimeoutCycles(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .obi_req_i   (obi_req_i),
    .obi_gnt_o   (obi_gnt_o),
    .obi_addr_i  (obi_addr_i),
    .obi_we_i    (obi_we_i),
    .obi_be_i    (obi_be_i),
    .obi_wdata_i (obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o (obi_rdata_o),
    .obi_err_o   (obi_err_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .pprot_o     (pprot_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pready_i    (pready_i),
    .prdata_i    (prdata_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // Peripheral model: selected slot becomes ready after cur_wait ACCESS cycles.
  // Unselected slots drive ready/error high and junk data, which must be ignored.
  int          cur_wait = 0;
  logic [31:0] cur_rdata = '0;
  logic        cur_err = 1'b0;
  int          acc_cnt = 0;

  always @(posedge clk_i) acc_cnt <= penable_o ? acc_cnt + 1 : 0;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      prdata_i[j] = psel_o[j] ? cur_rdata : (32'hBAD0_0000 | 32'(j));
    end
    pready_i  = ~psel_o | (((penable_o != 1'b0) && (acc_cnt >= cur_wait)) ? psel_o : 4'b0);
    pslverr_i = ~psel_o | (cur_err ? psel_o : 4'b0);
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [3:0]  exp_psel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    exp_t e;
    int   t;
    bit   done;
    cur_wait  = v.waits;
    cur_rdata = v.prdata;
    cur_err   = v.slverr;
    @(posedge clk_i);
    #1;
    obi_req_i   = 1'b1;
    obi_addr_i  = v.addr;
    obi_we_i    = v.we;
    obi_be_i    = v.be;
    obi_wdata_i = v.wdata;
    exp_q.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    @(negedge clk_i);
    check({name, " gnt"}, 32'(obi_gnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    obi_req_i = 1'b0;
    t = 0;
    done = 0;
    while (!done && t < 40) begin
      @(negedge clk_i);
      t++;
      if (v.exp_psel != 4'b0 && t == 1) begin
        check({name, " setup psel"}, 32'(psel_o), 32'(v.exp_psel));
        check({name, " setup penable"}, 32'(penable_o), 32'd0);
        check({name, " paddr"}, paddr_o, v.addr);
        check({name, " pwrite"}, 32'(pwrite_o), 32'(v.we));
        check({name, " pstrb"}, 32'(pstrb_o), v.we ? 32'(v.be) : 32'd0);
        if (v.we) check({name, " pwdata"}, pwdata_o, v.wdata);
      end
      if (v.exp_psel != 4'b0 && t == 2) begin
        check({name, " access psel"}, 32'(psel_o), 32'(v.exp_psel));
        check({name, " access penable"}, 32'(penable_o), 32'd1);
        check({name, " access paddr"}, paddr_o, v.addr);
      end
      if (v.exp_psel == 4'b0 && !obi_rvalid_o) begin
        check({name, " miss psel"}, 32'(psel_o), 32'd0);
      end
      if (obi_rvalid_o) begin
        done = 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: unexpected rvalid, none pending", name);
        end else begin
          e = exp_q.pop_front();
          check({name, " rdata"}, obi_rdata_o, e.rdata);
          check({name, " err"}, 32'(obi_err_o), 32'(e.err));
          check({name, " latency"}, 32'(t), 32'(e.lat));
          check({name, " resp psel"}, 32'(psel_o), 32'd0);
          check({name, " resp penable"}, 32'(penable_o), 32'd0);
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no rvalid within 40 cycles, got none, want one", name);
      exp_q.delete();
    end
    @(negedge clk_i);
    check({name, " rvalid one cycle"}, 32'(obi_rvalid_o), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{Base + 32'h1004, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0,
                4'b0010, 32'h0, 1'b0, 3};
    vecs[1] = '{Base + 32'h2000, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678, 1'b0,
                4'b0100, 32'h1234_5678, 1'b0, 6};
    vecs[2] = '{Base + 32'h4000, 1'b0, 4'hF, 32'h0, 0, 32'h7777_7777, 1'b0,
                4'b0000, 32'h0, 1'b1, 1};
    vecs[3] = '{Base - 32'h4, 1'b0, 4'hF, 32'h0, 0, 32'h7777_7777, 1'b0,
                4'b0000, 32'h0, 1'b1, 1};
    vecs[4] = '{Base + 32'h0010, 1'b1, 4'h3, 32'h1122_3344, 1, 32'h6666_6666, 1'b1,
                4'b0001, 32'h0, 1'b1, 4};
    vecs[5] = '{Base + 32'h0FFC, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b1,
                4'b0001, 32'hCAFE_F00D, 1'b1, 3};
    vecs[6] = '{Base + 32'h3008, 1'b0, 4'hF, 32'h0, 100, 32'h9999_9999, 1'b0,
                4'b1000, 32'h0, 1'b1, 10};
    vecs[7] = '{Base + 32'h3008, 1'b0, 4'hF, 32'h0, 7, 32'h0F0F_0F0F, 1'b0,
                4'b1000, 32'h0F0F_0F0F, 1'b0, 10};
    vecs[8] = '{Base + 32'h4FFC, 1'b1, 4'hF, 32'hFFFF_0000, 0, 32'h0, 1'b0,
                4'b0000, 32'h0, 1'b1, 1};
    vecs[9] = '{Base + 32'h2100, 1'b1, 4'b0101, 32'hA0B0_C0D0, 2, 32'h4444_4444, 1'b0,
                4'b0100, 32'h0, 1'b0, 5};

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("reset gnt", 32'(obi_gnt_o), 32'd0);
    check("reset rvalid", 32'(obi_rvalid_o), 32'd0);
    check("reset psel", 32'(psel_o), 32'd0);
    check("reset penable", 32'(penable_o), 32'd0);
    check("reset paddr", paddr_o, 32'd0);
    check("reset rdata", obi_rdata_o, 32'd0);
    check("reset pprot", 32'(pprot_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Request held high: grants only in IDLE, every 4 cycles; reset during the third ACCESS.
    cur_wait  = 0;
    cur_rdata = 32'hA5A5_0001;
    cur_err   = 1'b0;
    @(posedge clk_i);
    #1;
    obi_req_i   = 1'b1;
    obi_addr_i  = Base + 32'h1000;
    obi_we_i    = 1'b0;
    obi_be_i    = 4'hF;
    obi_wdata_i = 32'h0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      if (k % 4 == 0) exp_q.push_back('{32'hA5A5_0001, 1'b0, 3});
      check($sformatf("b2b gnt k%0d", k), 32'(obi_gnt_o), 32'(k % 4 == 0));
      check($sformatf("b2b rvalid k%0d", k), 32'(obi_rvalid_o), 32'(k % 4 == 3));
      if (obi_rvalid_o && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("b2b rdata k%0d", k), obi_rdata_o, e.rdata);
        check($sformatf("b2b err k%0d", k), 32'(obi_err_o), 32'(e.err));
      end
    end
    check("b2b access penable", 32'(penable_o), 32'd1);
    check("b2b access psel", 32'(psel_o), 32'b0010);
    #1;
    rst_ni    = 1'b0;
    obi_req_i = 1'b0;
    #1;
    check("midreset psel", 32'(psel_o), 32'd0);
    check("midreset penable", 32'(penable_o), 32'd0);
    check("midreset rvalid", 32'(obi_rvalid_o), 32'd0);
    // The aborted transfer never gets a response.
    exp_q.delete();
    repeat (2) begin
      @(negedge clk_i);
      check("in reset rvalid", 32'(obi_rvalid_o), 32'd0);
      check("in reset psel", 32'(psel_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post reset rvalid", 32'(obi_rvalid_o), 32'd0);
    check("post reset psel", 32'(psel_o), 32'd0);
    run_txn(vecs[0], "restart write");
    run_txn(vecs[1], "restart read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
